// File: rtl/csa_accum_pipe.sv
// Streaming carry-save multi-operand accumulator.
// A chunked carry-propagate adder resolves the redundant pair at the end of each group.
module csa_accum_pipe #(
  parameter int unsigned IN_W      = 24,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned CPA_CHUNK = 8,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned SIGNED    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_sub,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count
);

  localparam int unsigned NCHUNK = (ACC_W + CPA_CHUNK - 1) / CPA_CHUNK;
  localparam int unsigned PAD_W  = NCHUNK * CPA_CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned EXT_W  = ACC_W - IN_W;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);
  localparam logic [PAD_W-1:0] CHUNK_MASK = PAD_W'({CPA_CHUNK{1'b1}});

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0]   s_q, c_q, result_q;
  logic [PAD_W-1:0]   work_q, work_nxt;
  logic [CNT_W-1:0]   count_q;
  logic [IDX_W-1:0]   idx_q;
  logic               cin_q;

  logic               sign_bit;
  logic [ACC_W-1:0]   x_ext, x_op;
  logic [ACC_W-2:0]   maj;
  int unsigned        sh;
  logic [PAD_W-1:0]   s_pad, c_pad;
  logic [CPA_CHUNK-1:0] s_chunk, c_chunk;
  logic [CPA_CHUNK:0] chunk_sum;

  // Operand extension, optional inversion and 3:2 majority (top carry bit wraps away)
  always_comb begin
    sign_bit = (SIGNED != 0) ? in_data[IN_W-1] : 1'b0;
    x_ext    = {{EXT_W{sign_bit}}, in_data};
    x_op     = in_sub ? ~x_ext : x_ext;
    maj      = (s_q[ACC_W-2:0] & c_q[ACC_W-2:0]) |
               (s_q[ACC_W-2:0] & x_op[ACC_W-2:0]) |
               (c_q[ACC_W-2:0] & x_op[ACC_W-2:0]);
  end

  // One CPA chunk per RESOLVE cycle; zero padding makes the top chunk partial
  always_comb begin
    sh        = 32'(idx_q) * CPA_CHUNK;
    s_pad     = PAD_W'(s_q);
    c_pad     = PAD_W'(c_q);
    s_chunk   = CPA_CHUNK'(s_pad >> sh);
    c_chunk   = CPA_CHUNK'(c_pad >> sh);
    chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + (CPA_CHUNK + 1)'(cin_q);
    work_nxt  = (work_q & ~(CHUNK_MASK << sh)) |
                (PAD_W'(chunk_sum[CPA_CHUNK-1:0]) << sh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = !clr;
        if (in_valid && in_last) state_nxt = RESOLVE;
      end
      RESOLVE: begin
        if (idx_q == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
    if (clr) state_nxt = ACCUM;
  end

  // Datapath: carry-save fold, chunked resolve, group clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q      <= '0;
      c_q      <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      cin_q    <= 1'b0;
      work_q   <= '0;
      result_q <= '0;
    end else if (clr) begin
      s_q     <= '0;
      c_q     <= '0;
      count_q <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            s_q <= s_q ^ c_q ^ x_op;
            c_q <= {maj, in_sub};
            if (count_q != '1) count_q <= count_q + CNT_W'(1);
            if (in_last) begin
              idx_q <= '0;
              cin_q <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          work_q <= work_nxt;
          cin_q  <= chunk_sum[CPA_CHUNK];
          idx_q  <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) result_q <= work_nxt[ACC_W-1:0];
        end
        DONE: begin
          if (out_ready) begin
            s_q     <= '0;
            c_q     <= '0;
            count_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = result_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_csa_accum_pipe.sv
// Scoreboard bench for csa_accum_pipe: an unsigned and a signed instance share stimulus,
// and a monitor checks every delivered result against hand-computed values.
module tb_csa_accum_pipe;

  localparam int unsigned IN_W  = 24;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_sub = 1'b0;
  logic              in_last = 1'b0;
  logic              out_ready = 1'b1;
  logic [IN_W-1:0]   in_data = '0;

  logic              in_ready, out_valid;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_count;
  logic              in_ready_s, out_valid_s;
  logic [ACC_W-1:0]  out_data_s;
  logic [CNT_W-1:0]  out_count_s;

  always #5 clk = ~clk;

  csa_accum_pipe #(.SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  csa_accum_pipe #(.SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_count(out_count_s)
  );

  typedef struct {
    logic [31:0] exp_u;
    logic [31:0] exp_s;
    logic [15:0] cnt;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop one expectation per delivered result
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (out_valid && !prev_valid) begin
        rise_cyc = cyc;
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got 0x%08h with no expectation queued", out_data);
        end else begin
          e = sb.pop_front();
          chk("data_unsigned", out_data, e.exp_u);
          chk("data_signed", out_data_s, e.exp_s);
          chk("count", 32'(out_count), 32'(e.cnt));
          chk("count_signed", 32'(out_count_s), 32'(e.cnt));
          chk("valid_signed", 32'(out_valid_s), 32'd1);
          chk("latency", 32'(rise_cyc - e.acc_cyc), 32'd4);
        end
      end
    end
    prev_valid = out_valid;
  end

  task automatic send(input logic [23:0] d, input logic sub, input logic last, input logic push,
                      input logic [31:0] eu, input logic [31:0] es, input logic [15:0] cnt);
    int   n = 0;
    exp_t e;
    in_valid = 1'b1; in_data = d; in_sub = sub; in_last = last;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready low for %0d cycles", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sub = 1'b0; in_last = 1'b0;
    if (last && push) begin
      e.exp_u = eu; e.exp_s = es; e.cnt = cnt; e.acc_cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still pending", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, required finish before 100us");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Single beat
    send(24'hFFFFFF, 1'b0, 1'b1, 1'b1, 32'h00FFFFFF, 32'hFFFFFFFF, 16'd1);
    wait_drain();

    // Three back-to-back beats; in_ready low through RESOLVE
    send(24'hFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0);
    send(24'hFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0);
    send(24'hFFFFFF, 1'b0, 1'b1, 1'b1, 32'h02FFFFFD, 32'hFFFFFFFD, 16'd3);
    repeat (4) begin
      @(negedge clk);
      chk("in_ready_in_resolve", 32'(in_ready), 32'd0);
    end
    wait_drain();

    // Add then subtract
    send(24'd100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0);
    send(24'd300, 1'b1, 1'b1, 1'b1, 32'hFFFFFF38, 32'hFFFFFF38, 16'd2);
    wait_drain();

    // Sign extension versus zero extension
    send(24'h800000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0);
    send(24'h000001, 1'b0, 1'b1, 1'b1, 32'h00800001, 32'hFF800001, 16'd2);
    wait_drain();

    // Subtract-only group wraps below zero
    send(24'd1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0);
    send(24'd2, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFD, 16'd2);
    wait_drain();

    // Back-pressure in DONE: result held, operands ignored
    out_ready = 1'b0;
    send(24'd1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0);
    send(24'd2, 1'b0, 1'b1, 1'b1, 32'd3, 32'd3, 16'd2);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 24'h000123; in_last = 1'b1;
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_data", out_data, 32'd3);
      chk("stall_out_count", 32'(out_count), 32'd2);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    for (int i = 0; i < 4; i++) send(24'd7, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0);
    send(24'd7, 1'b0, 1'b1, 1'b1, 32'h23, 32'h23, 16'd5);
    wait_drain();

    // Clear mid-group; the operand offered with clr must be refused
    send(24'h000111, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0);
    send(24'h000222, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0);
    clr = 1'b1; in_valid = 1'b1; in_data = 24'h000055; in_last = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(24'h000010, 1'b0, 1'b1, 1'b1, 32'h10, 32'h10, 16'd1);
    wait_drain();

    // Asynchronous reset in the middle of RESOLVE
    send(24'h000020, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 16'd0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_data", out_data, 32'h0);
    chk("async_rst_out_count", 32'(out_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("post_rst_no_result", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    send(24'd5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0);
    send(24'd6, 1'b0, 1'b1, 1'b1, 32'd11, 32'd11, 16'd2);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
